// File: rtl/sobel_pkg.sv
// Types and constants shared by the Sobel window scheduler and its line buffer.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // A window column carries three vertically stacked pixels: {top, mid, bottom}.
  localparam int COL_TAPS = 3;

  function automatic int col_width(input int pix_bits);
    return COL_TAPS * pix_bits;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two image rows indexed by column; a write pushes row y-1 into the y-2 slot
// and stores the new pixel as row y-1. Reads are combinational (read-before-write).
module sobel_line_buffer #(
  parameter int WIDTH     = 768,
  parameter int ADDR_BITS = 10,
  parameter int PIX_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [PIX_BITS-1:0]   wr_pixel,
  output logic [2*PIX_BITS-1:0] rd_column
);

  logic [PIX_BITS-1:0] line0_mem [WIDTH];
  logic [PIX_BITS-1:0] line1_mem [WIDTH];

  // {row y-2, row y-1} at the current column, sampled before this cycle's write.
  assign rd_column = {line1_mem[addr], line0_mem[addr]};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line1_mem[addr] <= line0_mem[addr];
      line0_mem[addr] <= wr_pixel;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streams one raster-order frame into a 3x3 window and presents the outer columns
// (col_left -> kernel temp1, col_right -> kernel temp2) for every interior pixel.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int BITS_FOR_INDEX = 10,
  parameter int sizeOfWidth    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [sizeOfWidth-1:0]            in_pixel,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COL_TAPS*sizeOfWidth-1:0]   col_left,
  output logic [COL_TAPS*sizeOfWidth-1:0]   col_right,
  output logic [BITS_FOR_INDEX-1:0]         out_x,
  output logic [BITS_FOR_INDEX-1:0]         out_y,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int COL_W   = col_width(sizeOfWidth);
  localparam int ADDR_W  = $clog2(WIDTH);
  localparam logic [BITS_FOR_INDEX-1:0] X_LAST = BITS_FOR_INDEX'(WIDTH - 1);
  localparam logic [BITS_FOR_INDEX-1:0] Y_LAST = BITS_FOR_INDEX'(HEIGHT - 1);
  localparam logic [BITS_FOR_INDEX-1:0] EDGE   = BITS_FOR_INDEX'(2);

  state_t                    state_reg;
  logic [BITS_FOR_INDEX-1:0] x_reg;
  logic [BITS_FOR_INDEX-1:0] y_reg;
  logic [COL_W-1:0]          win_c0_reg;
  logic [COL_W-1:0]          win_c1_reg;
  logic                      out_valid_reg;
  logic [COL_W-1:0]          col_left_reg;
  logic [COL_W-1:0]          col_right_reg;
  logic [BITS_FOR_INDEX-1:0] out_x_reg;
  logic [BITS_FOR_INDEX-1:0] out_y_reg;
  logic                      frame_done_reg;

  logic                      accept;
  logic                      x_wrap;
  logic                      last_pixel;
  logic                      emit;
  logic [2*sizeOfWidth-1:0]  lb_column;
  logic [COL_W-1:0]          new_col;

  assign in_ready   = (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign accept     = in_valid && in_ready;
  assign x_wrap     = (x_reg == X_LAST);
  assign last_pixel = x_wrap && (y_reg == Y_LAST);
  // Only interior centres produce a window; the row never wraps because x>=2.
  assign emit       = accept && (x_reg >= EDGE) && (y_reg >= EDGE);
  assign new_col    = {lb_column, in_pixel};

  sobel_line_buffer #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_W),
    .PIX_BITS (sizeOfWidth)
  ) u_line_buffer (
    .clk      (clk),
    .wr_en    (accept),
    .addr     (x_reg[ADDR_W-1:0]),
    .wr_pixel (in_pixel),
    .rd_column(lb_column)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      win_c0_reg     <= '0;
      win_c1_reg     <= '0;
      out_valid_reg  <= 1'b0;
      col_left_reg   <= '0;
      col_right_reg  <= '0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            x_reg     <= '0;
            y_reg     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (x_wrap) begin
              x_reg <= '0;
              y_reg <= y_reg + 1'b1;
            end else begin
              x_reg <= x_reg + 1'b1;
            end
            if (last_pixel) begin
              state_reg <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!out_valid_reg || out_ready) begin
            state_reg      <= IDLE;
            frame_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A new window may replace a window consumed in the same cycle (no bubble).
      if (emit) begin
        out_valid_reg <= 1'b1;
        col_left_reg  <= win_c0_reg;
        col_right_reg <= new_col;
        out_x_reg     <= x_reg - 1'b1;
        out_y_reg     <= y_reg - 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (accept) begin
        win_c0_reg <= win_c1_reg;
        win_c1_reg <= new_col;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign col_left   = col_left_reg;
  assign col_right  = col_right_reg;
  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_done = frame_done_reg;

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

- Streaming scheduler that sequences one grayscale frame through the `sorbel_X` Sobel-X kernel.
- Accepts pixels in raster order over a valid/ready handshake and keeps two line buffers plus a 3x3 window.
- For every interior pixel it presents the window's left and right columns on the `temp1`/`temp2` format the kernel consumes, with output valid/ready backpressure.
- Sits between the BMP pixel reader and the edge-detect stage.

## Interface
- `WIDTH`, 768, image width in pixels (≥3)
- `HEIGHT`, 512, image height in pixels (≥3)
- `BITS_FOR_INDEX`, 10, x/y counter width, ceil(lg(max(WIDTH,HEIGHT)))
- `sizeOfWidth`, 8, bits per pixel
- `clk` input 1: the block's single clock
- `rst` input 1: synchronous, active-high reset
- `start` input 1: one-cycle pulse that begins a frame; ignored unless in IDLE
- `in_valid` input 1: pixel present
- `in_ready` output 1: block accepts pixel this cycle
- `in_pixel` input `sizeOfWidth`: raster-order pixel
- `out_valid` output 1: window columns valid
- `out_ready` input 1: downstream accepts window
- `col_left` output 3*`sizeOfWidth`: {top, mid, bottom} of column x-2; feeds `temp1`
- `col_right` output 3*`sizeOfWidth`: {top, mid, bottom} of column x; feeds `temp2`
- `out_x`, `out_y` output `BITS_FOR_INDEX` each: centre coordinate of the current window
- `busy` output 1: state ≠ IDLE
- `frame_done` output 1: one-cycle pulse after the final window is consumed

## Operation
- States:
  - IDLE: `start` → RUN; x/y counters cleared.
  - RUN: the pixel at (`WIDTH`-1, `HEIGHT`-1) is accepted → FLUSH.
  - FLUSH: the output register is empty, or is consumed this cycle → IDLE, asserting `frame_done` for that single cycle.
- Ready and accept:
  - `in_ready` = (state==RUN) && (!`out_valid` || `out_ready`).
  - A pixel is accepted when `in_valid` && `in_ready`.
- On accept of pixel (x,y):
  - Write it into the line buffers.
  - Shift the 3x3 window: the new column is {line1[x], line0[x], `in_pixel`}, where line1 holds row y-2 and line0 holds row y-1.
  - x increments; at `WIDTH`-1, x wraps to 0 and y increments.
- If x≥2 and y≥2, the output register loads on the next edge:
  - `col_left` = {p(x-2,y-2), p(x-2,y-1), p(x-2,y)}
  - `col_right` = {p(x,y-2), p(x,y-1), p(x,y)}
  - `out_x` = x-1, `out_y` = y-1
  - `out_valid` = 1
- Otherwise `out_valid` clears if `out_ready`; it holds if not.
- Output register contents are stable while `out_valid` && !`out_ready`.
- Accepting a pixel with an x≥2, y≥2 window and consuming the pending output in the same cycle is legal: the new data replaces the old with no bubble.
- Exactly (`WIDTH`-2)*(`HEIGHT`-2) windows per frame. Border pixels produce no output.
- The window does not wrap across rows; windows are emitted only for x≥2.
- Line buffer contents need no reset. The rows they hold are always rewritten before being read.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `col_left`=0, `col_right`=0, `out_x`=0, `out_y`=0, `busy`=0, `frame_done`=0. State = IDLE, counters = 0.
- Latency: accept of (x,y) → `out_valid` on the next cycle. Full throughput is 1 pixel/cycle when `out_ready` is held high.
- `start` during RUN or FLUSH is ignored. `start` in the same cycle as `rst` is ignored.
- `rst` mid-frame: next cycle is IDLE with all outputs at reset values, and the pending window is discarded.
- Line buffers: read-before-write in the same cycle. Synchronous 1-cycle read latency is not allowed; use a combinational read or an address look-ahead.

## Structure
- Shared package `sobel_pkg`: state enum (IDLE, RUN, FLUSH) and the column pack/unpack width constant 3*`sizeOfWidth`.
- Sub-module `sobel_line_buffer`: two `WIDTH`-deep x `sizeOfWidth` rows, indexed by x, returning {line1[x], line0[x]} and shifting on write.
- Instantiated by the top-level alongside `sorbel_X`:
  - `temp1` ← `col_left`
  - `temp2` ← `col_right`

## Test plan
- WIDTH=4, HEIGHT=3, p(x,y)=10x+y, `out_ready`=1, continuous `in_valid`:
  - Exactly 2 windows.
  - First window one cycle after accepting (2,2): `col_left`=24'h000102, `col_right`=24'h141516, `out_x`=1, `out_y`=1.
  - Second window: `col_left`=24'h0A0B0C, `col_right`=24'h1E1F20, `out_x`=2.
  - `frame_done` pulses once, then the block is back in IDLE.
- Same frame with `out_ready` low for 3 cycles while the first window is pending:
  - `in_ready`=0 and the outputs are held unchanged.
  - Windows are identical to the first scenario.
- WIDTH=5, HEIGHT=5, random `in_valid` and `out_ready`:
  - 9 windows, matching a software model of the column values and `out_x`/`out_y`.
- `rst` asserted after 7 of the 12 pixels:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A fresh `start` and full frame then produce correct results.
- `start` pulsed during RUN: no effect on the counters or the window count.
- Back-to-back frames (`start` issued in the cycle after `frame_done`):
  - Second frame's first window is correct; no stale rows from the first frame appear.
